// File: rtl/led_serial_rx_axis.sv
// Two-wire LED serial receiver: reassembles MSB-first 32-bit words onto an AXI-Stream master.
// Optional LED_RX_START_FRAME_FILTER_EN drops all-zero (APA102 start frame) words.
module led_serial_rx_axis #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_led_clk,
  input  logic        i_led_data,
  output logic [31:0] m_axis_data,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_timeout
);

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        clk_s1, clk_s2, clk_prev;
  logic        data_s1, data_s2;
  logic [31:0] shift_reg, hold_reg;
  logic [5:0]  bit_cnt;
  logic [15:0] idle_cnt;
  logic        tvalid, overflow, timeout;

  logic        ser_edge, word_done, keep;
  logic [31:0] next_word;

  always_comb begin
    ser_edge  = clk_s2 & ~clk_prev;
    next_word = {shift_reg[30:0], data_s2};
    word_done = ser_edge && (bit_cnt == 6'd31);
`ifdef LED_RX_START_FRAME_FILTER_EN
    keep      = (next_word != 32'h0);
`else
    keep      = 1'b1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      clk_s1    <= 1'b0;
      clk_s2    <= 1'b0;
      clk_prev  <= 1'b0;
      data_s1   <= 1'b0;
      data_s2   <= 1'b0;
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      tvalid    <= 1'b0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      clk_s1   <= i_led_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= i_led_data;
      data_s2  <= data_s1;
      timeout  <= 1'b0;

      // A serial edge in the timeout cycle takes priority over the discard.
      if (ser_edge) begin
        shift_reg <= next_word;
        bit_cnt   <= word_done ? 6'd0 : bit_cnt + 6'd1;
        idle_cnt  <= '0;
      end else if (bit_cnt == 6'd0) begin
        idle_cnt  <= '0;
      end else if (idle_cnt == IDLE_LAST) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
        idle_cnt  <= '0;
        timeout   <= 1'b1;
      end else begin
        idle_cnt  <= idle_cnt + 16'd1;
      end

      if (word_done && keep) begin
        if (!tvalid || m_axis_tready) begin
          hold_reg <= next_word;
          tvalid   <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (tvalid && m_axis_tready) begin
        tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_data   = hold_reg;
  assign m_axis_tvalid = tvalid;
  assign o_busy        = (bit_cnt != 6'd0);
  assign o_overflow    = overflow;
  assign o_timeout     = timeout;

endmodule

// File: tb/tb_led_serial_rx_axis.sv
// Directed bench for led_serial_rx_axis: one instance at the default timeout for slow
// serial clocks, one at TIMEOUT_CYCLES=64 for handshake, stall and reset scenarios.
module tb_led_serial_rx_axis;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led_clk = 1'b0;
  logic led_data = 1'b0;

  logic [31:0] data_a, data_b;
  logic        tvalid_a, tvalid_b;
  logic        tready_a = 1'b1;
  logic        tready_b = 1'b0;
  logic        busy_a, busy_b, ovf_a, ovf_b, to_a, to_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] beats_a[$];
  logic [31:0] beats_b[$];

  always #5 clk = ~clk;

  led_serial_rx_axis dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_led_clk(led_clk), .i_led_data(led_data),
    .m_axis_data(data_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
    .o_busy(busy_a), .o_overflow(ovf_a), .o_timeout(to_a)
  );

  led_serial_rx_axis #(.TIMEOUT_CYCLES(64)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_led_clk(led_clk), .i_led_data(led_data),
    .m_axis_data(data_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
    .o_busy(busy_b), .o_overflow(ovf_b), .o_timeout(to_b)
  );

  always @(posedge clk) begin
    if (tvalid_a && tready_a) beats_a.push_back(data_a);
    if (tvalid_b && tready_b) beats_b.push_back(data_b);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    led_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    beats_a.delete();
    beats_b.delete();
  endtask

  // Starts and ends on a negedge with the serial clock low.
  task automatic send_bit(input logic b, input int half);
    led_data = b;
    repeat (half) @(negedge clk);
    led_clk = 1'b1;
    repeat (half) @(negedge clk);
    led_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input int half);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i], half);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (tvalid_b !== 1'b0 || data_b !== 32'h0) begin
      errors++; $display("FAIL reset_axis tvalid=%b data=%h expected 0/0", tvalid_b, data_b);
    end
    checks++;
    if (busy_b !== 1'b0 || ovf_b !== 1'b0 || to_b !== 1'b0 || tvalid_a !== 1'b0) begin
      errors++; $display("FAIL reset_status busy=%b ovf=%b to=%b tvalid_a=%b expected 0", busy_b, ovf_b, to_b, tvalid_a);
    end
  endtask

  task automatic test_single_latency();
    logic [31:0] w;
    w = 32'hE0FF0000;
    do_reset();
    send_bits(w, 31, 61);
    led_data = w[0];
    repeat (61) @(negedge clk);
    led_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tvalid_a !== 1'b0) begin
      errors++; $display("FAIL latency_early tvalid=%b expected 0", tvalid_a);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tvalid_a !== 1'b1 || data_a !== w) begin
      errors++; $display("FAIL latency_beat tvalid=%b data=%h expected 1/%h", tvalid_a, data_a, w);
    end
    repeat (61) @(negedge clk);
    led_clk = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (beats_a.size() !== 1 || ovf_a !== 1'b0 || tvalid_a !== 1'b0) begin
      errors++; $display("FAIL single_beat beats=%0d ovf=%b tvalid=%b expected 1/0/0", beats_a.size(), ovf_a, tvalid_a);
    end else begin
      checks++;
      if (beats_a[0] !== w) begin
        errors++; $display("FAIL single_data got %h expected %h", beats_a[0], w);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    tready_b = 1'b0;
    send_bits(32'h12345678, 32, 4);
    send_bits(32'hFFFFFFFF, 32, 4);
    repeat (5) @(negedge clk);
    checks++;
    if (tvalid_b !== 1'b1 || data_b !== 32'h12345678 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL overflow_hold tvalid=%b data=%h ovf=%b expected 1/12345678/1", tvalid_b, data_b, ovf_b);
    end
    tready_b = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (beats_b.size() !== 1 || tvalid_b !== 1'b0) begin
      errors++; $display("FAIL overflow_drain beats=%0d tvalid=%b expected 1/0", beats_b.size(), tvalid_b);
    end else begin
      checks++;
      if (beats_b[0] !== 32'h12345678) begin
        errors++; $display("FAIL overflow_data got %h expected 12345678", beats_b[0]);
      end
    end
    tready_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    w1 = 32'hCAFEF00D;
    w2 = 32'h0F1E2D3C;
    do_reset();
    tready_b = 1'b0;
    send_bits(w1, 32, 4);
    send_bits(w2, 31, 4);
    led_data = w2[0];
    repeat (4) @(negedge clk);
    led_clk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tvalid_b !== 1'b1 || data_b !== w1) begin
      errors++; $display("FAIL b2b_hold tvalid=%b data=%h expected 1/%h", tvalid_b, data_b, w1);
    end
    tready_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tvalid_b !== 1'b1 || data_b !== w2) begin
      errors++; $display("FAIL b2b_reload tvalid=%b data=%h expected 1/%h", tvalid_b, data_b, w2);
    end
    repeat (4) @(negedge clk);
    led_clk = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (beats_b.size() !== 2 || ovf_b !== 1'b0) begin
      errors++; $display("FAIL b2b_count beats=%0d ovf=%b expected 2/0", beats_b.size(), ovf_b);
    end else begin
      checks++;
      if (beats_b[0] !== w1 || beats_b[1] !== w2) begin
        errors++; $display("FAIL b2b_order got %h %h expected %h %h", beats_b[0], beats_b[1], w1, w2);
      end
    end
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    tready_b = 1'b1;
    send_bits(32'hFFC00000, 10, 4);
    repeat (3) @(negedge clk);
    checks++;
    if (busy_b !== 1'b1) begin
      errors++; $display("FAIL timeout_busy_before busy=%b expected 1", busy_b);
    end
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (to_b === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse pulses=%0d busy=%b expected 1/0", pulses, busy_b);
    end
    send_bits(32'hA5A5A5A5, 32, 4);
    repeat (5) @(negedge clk);
    checks++;
    if (beats_b.size() !== 1) begin
      errors++; $display("FAIL timeout_recover beats=%0d expected 1", beats_b.size());
    end else begin
      checks++;
      if (beats_b[0] !== 32'hA5A5A5A5) begin
        errors++; $display("FAIL timeout_data got %h expected a5a5a5a5", beats_b[0]);
      end
    end
    tready_b = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    tready_b = 1'b0;
    send_bits(32'h11111111, 32, 4);
    send_bits(32'h22222222, 32, 4);
    send_bits(32'h33333333, 20, 4);
    checks++;
    if (ovf_b !== 1'b1 || busy_b !== 1'b1 || tvalid_b !== 1'b1) begin
      errors++; $display("FAIL midrst_setup ovf=%b busy=%b tvalid=%b expected 1/1/1", ovf_b, busy_b, tvalid_b);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (tvalid_b !== 1'b0 || busy_b !== 1'b0 || ovf_b !== 1'b0 || data_b !== 32'h0) begin
      errors++; $display("FAIL midrst_clear tvalid=%b busy=%b ovf=%b data=%h expected 0", tvalid_b, busy_b, ovf_b, data_b);
    end
    tready_b = 1'b1;
    send_bits(32'h0000FFFF, 32, 4);
    repeat (5) @(negedge clk);
    checks++;
    if (beats_b.size() !== 1) begin
      errors++; $display("FAIL midrst_count beats=%0d expected 1", beats_b.size());
    end else begin
      checks++;
      if (beats_b[0] !== 32'h0000FFFF) begin
        errors++; $display("FAIL midrst_data got %h expected 0000ffff", beats_b[0]);
      end
    end
    tready_b = 1'b0;
  endtask

  task automatic test_start_frame();
    do_reset();
    tready_b = 1'b1;
    send_bits(32'h00000000, 32, 4);
    send_bits(32'hE1010203, 32, 4);
    repeat (5) @(negedge clk);
`ifdef LED_RX_START_FRAME_FILTER_EN
    checks++;
    if (beats_b.size() !== 1) begin
      errors++; $display("FAIL filter_count beats=%0d expected 1", beats_b.size());
    end else begin
      checks++;
      if (beats_b[0] !== 32'hE1010203) begin
        errors++; $display("FAIL filter_data got %h expected e1010203", beats_b[0]);
      end
    end
`else
    checks++;
    if (beats_b.size() !== 2) begin
      errors++; $display("FAIL zero_count beats=%0d expected 2", beats_b.size());
    end else begin
      checks++;
      if (beats_b[0] !== 32'h0 || beats_b[1] !== 32'hE1010203) begin
        errors++; $display("FAIL zero_data got %h %h expected 00000000 e1010203", beats_b[0], beats_b[1]);
      end
    end
`endif
    checks++;
    if (ovf_b !== 1'b0) begin
      errors++; $display("FAIL start_frame_ovf ovf=%b expected 0", ovf_b);
    end
    tready_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    test_start_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_serial_rx_axis.md
Name: led_serial_rx_axis

Overview:
- Receive-side counterpart of the LED-bar serial shifter: samples an external two-wire LED clock/data stream (MSB first, data valid on rising clock edge).
- Reassembles 32-bit words and presents them on an AXI-Stream master with a one-word holding buffer.
- Used as a loopback/monitor of the Blinkt driver output, and as a target for bench verification of the transmit path.
- Includes a stall timeout to realign after aborted transfers.

Parameters:
- TIMEOUT_CYCLES, 1024, i_clk cycles without a serial rising edge mid-word before the partial word is discarded; legal range 8..65535.

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  synchronous active-low reset.
- i_led_clk  input  1  serial clock, asynchronous to i_clk.
- i_led_data  input  1  serial data, asynchronous to i_clk.
- m_axis_data  output  32  received word.
- m_axis_tvalid  output  1  holding register holds an unconsumed word.
- m_axis_tready  input  1  downstream accepts.
- o_busy  output  1  bit count nonzero (word in progress).
- o_overflow  output  1  sticky: a completed word was dropped.
- o_timeout  output  1  one-cycle pulse when a partial word is discarded.

Behaviour:
- Reset: all registers and outputs cleared on any i_clk edge with i_reset_n=0. m_axis_data=0, tvalid=0, o_busy=0, o_overflow=0, o_timeout=0. Sync flops cleared to 0. Reset mid-word discards the partial word and any held word.
- Input sync: i_led_clk and i_led_data each pass through a 2-FF synchronizer. A third register holds the previous synced clock.
- Edge detect: edge = synced_clk & ~prev_clk. Data is sampled from synced_data in the same cycle. Serial clock high/low phases must each be >= 3 i_clk cycles; shorter phases are unsupported.
- Shift: on edge, shift_reg <= {shift_reg[30:0], synced_data} and bit_cnt increments (6-bit, 0..31).
- Completion: an edge with bit_cnt==31 completes the word. bit_cnt returns to 0 and the assembled word goes to the holding logic.
- Latency: m_axis_tvalid is high on the 3rd i_clk edge after the first i_clk edge that samples i_led_clk high on the 32nd bit.
- Holding register (one entry), on completion:
  - tvalid=0: load word, tvalid<=1.
  - tvalid=1 and tready=1 in the same cycle: old word handshakes, new word loads, tvalid stays 1, no overflow.
  - tvalid=1 and tready=0: new word dropped, held word unchanged, o_overflow<=1 until reset.
- AXIS rules: tvalid=1 and tready=1 without a completion gives tvalid<=0. m_axis_data is stable while tvalid=1 and tready=0. tvalid never depends combinationally on tready.
- Timeout:
  - 16-bit idle counter clears on every edge and whenever bit_cnt==0.
  - Otherwise it increments each cycle.
  - On reaching TIMEOUT_CYCLES-1: bit_cnt<=0, shift_reg<=0, counter<=0, o_timeout pulses 1 cycle, holding register unaffected.
  - An edge in that same cycle wins: the bit is shifted and no timeout fires.
- Bit count never exceeds 31. A word is only emitted after exactly 32 edges.
- o_busy = (bit_cnt != 0).

Optional Feature:
- Macro LED_RX_START_FRAME_FILTER_EN.
- Defined: a completed word equal to 32'h00000000 (APA102 start frame) is silently discarded. It is not loaded, does not set overflow, and no other state changes.
- Undefined: all-zero words are delivered like any other word.

Test Plan:
- Serial 32'hE0FF0000 at 61-cycle half-period, tready=1 -> one beat, m_axis_data=32'hE0FF0000; tvalid rises 3 cycles after 32nd clock high; o_overflow=0.
- Two words 32'h12345678 then 32'hFFFFFFFF with tready=0 -> tvalid held with 32'h12345678 stable; second dropped, o_overflow=1; raise tready -> one beat 32'h12345678 only.
- Completion coincides with accepting a held word -> both words delivered in order, o_overflow=0.
- 10 bits sent then clock stalls, TIMEOUT_CYCLES=64 -> o_timeout pulses once, o_busy=0; next full word 32'hA5A5A5A5 received correctly.
- Reset asserted after 20 bits and after a word is held -> tvalid=0, o_busy=0, o_overflow=0; next 32 bits 32'h0000FFFF received intact.
- Send 32'h00000000 then 32'hE1010203 -> with LED_RX_START_FRAME_FILTER_EN only 32'hE1010203 emitted; without it two beats.
